// File: rtl/vfpu_lzc_pipe_if.sv
// Handshake and data bundle for the multi-lane first-set/first-clear detector.
// The slave modport is the detector itself; the master modport is the producer/consumer side.
interface vfpu_lzc_pipe_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int CNT_W = $clog2(WIDTH)
);
   logic                   in_valid_i;
   logic                   in_ready_o;
   logic [LANES*WIDTH-1:0] in_data_i;
   logic [1:0]             in_mode_i;
   logic [LANES-1:0]       in_lane_en_i;
   logic                   out_valid_o;
   logic                   out_ready_i;
   logic [LANES*CNT_W-1:0] out_idx_o;
   logic [LANES-1:0]       out_none_o;
   logic                   out_all_none_o;

   modport slave (
      input  in_valid_i, in_data_i, in_mode_i, in_lane_en_i, out_ready_i,
      output in_ready_o, out_valid_o, out_idx_o, out_none_o, out_all_none_o
   );

   modport master (
      output in_valid_i, in_data_i, in_mode_i, in_lane_en_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_idx_o, out_none_o, out_all_none_o
   );
endinterface

// File: rtl/vfpu_lzc_pipe.sv
// Two-stage multi-lane leading/trailing one/zero detector with valid/ready on both sides.
// Stage 1 resolves per-group hits in scan order; stage 2 picks the first hit group per lane.
module vfpu_lzc_pipe #(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int CHUNK = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic           clk_i,
   input  logic           clear_i,
   vfpu_lzc_pipe_if.slave bus
);
   localparam int NG = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PW = NG * CHUNK;
   localparam int LW = $clog2(CHUNK);

   // Reorders the operand so bit 0 is the first bit in scan order; padding stays 0 and never matches.
   function automatic logic [PW-1:0] scan_order(input logic [WIDTH-1:0] x, input logic [1:0] mode);
      logic [PW-1:0]    s;
      logic [WIDTH-1:0] m;
      s = '0;
      m = mode[1] ? ~x : x;
      for (int k = 0; k < WIDTH; k++) s[k] = mode[0] ? m[k] : m[WIDTH-1-k];
      return s;
   endfunction

   function automatic logic [LW-1:0] first_set(input logic [CHUNK-1:0] g);
      logic [LW-1:0] r;
      r = '0;
      for (int b = CHUNK - 1; b >= 0; b--) if (g[b]) r = LW'(b);
      return r;
   endfunction

   logic                   vld_p1, vld_p2;
   logic                   s1_adv, s2_adv;
   logic [PW-1:0]          scan_c  [LANES];
   logic [NG-1:0]          any_c   [LANES];
   logic [LW-1:0]          lidx_c  [LANES][NG];
   logic [NG-1:0]          any_p1  [LANES];
   logic [LW-1:0]          lidx_p1 [LANES][NG];
   logic [CNT_W-1:0]       idx_c   [LANES];
   logic [LANES-1:0]       none_c;
   logic [CNT_W-1:0]       idx_p2  [LANES];
   logic [LANES-1:0]       none_p2;

   assign s2_adv = ~vld_p2 | bus.out_ready_i;
   assign s1_adv = ~vld_p1 | s2_adv;

   // Stage 1: per-lane group hit flags and local indices
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         scan_c[l] = bus.in_lane_en_i[l] ? scan_order(bus.in_data_i[l*WIDTH +: WIDTH], bus.in_mode_i) : '0;
         for (int g = 0; g < NG; g++) begin
            any_c[l][g]  = |scan_c[l][g*CHUNK +: CHUNK];
            lidx_c[l][g] = first_set(scan_c[l][g*CHUNK +: CHUNK]);
         end
      end
   end

   // Stage 2: first hit group per lane, combined into a global index
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         idx_c[l]  = '0;
         none_c[l] = 1'b1;
         for (int g = NG - 1; g >= 0; g--) begin
            if (any_p1[l][g]) begin
               idx_c[l]  = CNT_W'(g * CHUNK + int'(lidx_p1[l][g]));
               none_c[l] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         any_p1  <= '{default: '0};
         lidx_p1 <= '{default: '{default: '0}};
         idx_p2  <= '{default: '0};
         none_p2 <= '1;
      end else begin
         if (s1_adv) vld_p1 <= bus.in_valid_i;
         if (s1_adv && bus.in_valid_i) begin
            any_p1  <= any_c;
            lidx_p1 <= lidx_c;
         end
         if (s2_adv) vld_p2 <= vld_p1;
         if (s2_adv && vld_p1) begin
            idx_p2  <= idx_c;
            none_p2 <= none_c;
         end
      end
   end

   assign bus.in_ready_o     = s1_adv;
   assign bus.out_valid_o    = vld_p2;
   assign bus.out_none_o     = none_p2;
   assign bus.out_all_none_o = &none_p2;

   for (genvar l = 0; l < LANES; l++) begin : g_out
      assign bus.out_idx_o[l*CNT_W +: CNT_W] = idx_p2[l];
   end
endmodule

// File: tb/tb_vfpu_lzc_pipe.sv
// Directed bench for vfpu_lzc_pipe: 32-bit/4-lane instance plus a 5-bit/CHUNK=4 instance for partial groups.
module tb_vfpu_lzc_pipe;
  logic clk = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vfpu_lzc_pipe_if #(.WIDTH(32), .LANES(4), .CNT_W(5)) bus ();
  vfpu_lzc_pipe #(.WIDTH(32), .LANES(4), .CHUNK(8), .CNT_W(5)) dut (
    .clk_i(clk), .clear_i(clear), .bus(bus)
  );

  vfpu_lzc_pipe_if #(.WIDTH(5), .LANES(1), .CNT_W(3)) bus5 ();
  vfpu_lzc_pipe #(.WIDTH(5), .LANES(1), .CHUNK(4), .CNT_W(3)) dut5 (
    .clk_i(clk), .clear_i(clear), .bus(bus5)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int e0, input int e1, input int e2, input int e3,
                           input logic [3:0] enone);
    int e[4];
    e = '{e0, e1, e2, e3};
    check_eq({tag, " valid"}, bus.out_valid_o, 1);
    for (int n = 0; n < 4; n++)
      check_eq($sformatf("%s idx%0d", tag, n), bus.out_idx_o[n*5 +: 5], e[n]);
    check_eq({tag, " none"}, bus.out_none_o, enone);
    check_eq({tag, " all_none"}, bus.out_all_none_o, &enone);
  endtask

  task automatic run_beat(input string tag, input logic [127:0] data, input logic [1:0] mode,
                          input logic [3:0] en, input int e0, input int e1, input int e2,
                          input int e3, input logic [3:0] enone);
    bus.in_data_i    = data;
    bus.in_mode_i    = mode;
    bus.in_lane_en_i = en;
    bus.in_valid_i   = 1'b1;
    bus.out_ready_i  = 1'b1;
    #1;
    check_eq({tag, " in_ready"}, bus.in_ready_o, 1);
    tick();
    bus.in_valid_i = 1'b0;
    check_eq({tag, " lat1"}, bus.out_valid_o, 0);
    tick();
    check_out(tag, e0, e1, e2, e3, enone);
  endtask

  task automatic run5(input string tag, input logic [4:0] op, input logic [1:0] mode,
                      input int eidx, input logic enone);
    bus5.in_data_i    = op;
    bus5.in_mode_i    = mode;
    bus5.in_lane_en_i = 1'b1;
    bus5.in_valid_i   = 1'b1;
    tick();
    bus5.in_valid_i = 1'b0;
    tick();
    check_eq({tag, " valid"}, bus5.out_valid_o, 1);
    check_eq({tag, " idx"}, bus5.out_idx_o, eidx);
    check_eq({tag, " none"}, bus5.out_none_o, enone);
  endtask

  task automatic set_lane0(input logic [31:0] v);
    bus.in_data_i    = {96'h0, v};
    bus.in_mode_i    = 2'b00;
    bus.in_lane_en_i = 4'hF;
    bus.in_valid_i   = 1'b1;
  endtask

  initial begin
    clear            = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.in_mode_i    = 2'b00;
    bus.in_lane_en_i = 4'hF;
    bus.out_ready_i  = 1'b0;
    bus5.in_valid_i  = 1'b0;
    bus5.in_data_i   = '0;
    bus5.in_mode_i   = 2'b00;
    bus5.in_lane_en_i = 1'b1;
    bus5.out_ready_i = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    #1;
    check_eq("rst valid", bus.out_valid_o, 0);
    check_eq("rst idx", bus.out_idx_o, 0);
    check_eq("rst none", bus.out_none_o, 4'hF);
    check_eq("rst all_none", bus.out_all_none_o, 1);
    check_eq("rst in_ready", bus.in_ready_o, 1);

    run_beat("A lead1", {32'h00000000, 32'h80000000, 32'h00000001, 32'h00010000}, 2'b00, 4'hF,
             15, 31, 0, 0, 4'b1000);
    run_beat("B trail1", {32'h00000000, 32'h80000000, 32'h00000001, 32'h00010000}, 2'b01, 4'hF,
             16, 0, 31, 0, 4'b1000);
    run_beat("C lead0", {32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFF00000}, 2'b10, 4'hF,
             12, 0, 0, 31, 4'b0010);
    run_beat("D trail0", {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000}, 2'b11, 4'hF,
             0, 16, 0, 31, 4'b0100);
    run_beat("E lane_en", {4{32'h80000000}}, 2'b00, 4'b0101, 0, 0, 0, 0, 4'b1010);
    run_beat("F all_none", 128'h0, 2'b00, 4'hF, 0, 0, 0, 0, 4'b1111);
    run_beat("G trail1", {32'h00008000, 32'h80000001, 32'h00000100, 32'h01000000}, 2'b01, 4'hF,
             24, 8, 0, 15, 4'b0000);
    run_beat("H lead1", {32'h00000080, 32'h00400000, 32'h0F000000, 32'hFFFFFFFF}, 2'b00, 4'hF,
             0, 4, 9, 24, 4'b0000);

    // Backpressure: three beats against a stalled consumer
    tick();
    bus.out_ready_i = 1'b0;
    set_lane0(32'h00010000);
    #1;
    check_eq("stall acc1 ready", bus.in_ready_o, 1);
    tick();
    set_lane0(32'h00000100);
    #1;
    check_eq("stall acc2 ready", bus.in_ready_o, 1);
    tick();
    set_lane0(32'h40000000);
    #1;
    check_eq("stall full ready", bus.in_ready_o, 0);
    check_eq("stall full valid", bus.out_valid_o, 1);
    check_eq("stall full idx", bus.out_idx_o[4:0], 15);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("stall hold%0d ready", c), bus.in_ready_o, 0);
      check_eq($sformatf("stall hold%0d valid", c), bus.out_valid_o, 1);
      check_eq($sformatf("stall hold%0d idx", c), bus.out_idx_o[4:0], 15);
    end
    bus.out_ready_i = 1'b1;
    #1;
    check_eq("release comb ready", bus.in_ready_o, 1);
    tick();
    bus.in_valid_i = 1'b0;
    check_eq("rel beat2 valid", bus.out_valid_o, 1);
    check_eq("rel beat2 idx", bus.out_idx_o[4:0], 23);
    tick();
    check_eq("rel beat3 valid", bus.out_valid_o, 1);
    check_eq("rel beat3 idx", bus.out_idx_o[4:0], 1);
    tick();
    check_eq("rel no dup", bus.out_valid_o, 0);

    // Clear with two beats in flight
    bus.out_ready_i = 1'b0;
    set_lane0(32'h00010000);
    tick();
    set_lane0(32'h00000100);
    tick();
    check_eq("pre-clear valid", bus.out_valid_o, 1);
    clear = 1'b1;
    set_lane0(32'h40000000);
    tick();
    clear = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    #1;
    check_eq("clr valid", bus.out_valid_o, 0);
    check_eq("clr none", bus.out_none_o, 4'hF);
    check_eq("clr idx", bus.out_idx_o, 0);
    check_eq("clr in_ready", bus.in_ready_o, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("clr no stale%0d", c), bus.out_valid_o, 0);
    end

    // Partial last group: WIDTH=5, CHUNK=4
    run5("w5 lead1 00001", 5'b00001, 2'b00, 4, 1'b0);
    run5("w5 lead0 11111", 5'b11111, 2'b10, 0, 1'b1);
    run5("w5 trail0 11111", 5'b11111, 2'b11, 0, 1'b1);
    run5("w5 trail1 10000", 5'b10000, 2'b01, 4, 1'b0);
    run5("w5 trail0 01111", 5'b01111, 2'b11, 4, 1'b0);
    run5("w5 lead1 00100", 5'b00100, 2'b00, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
